// File: rtl/poly_loader.sv
// poly_loader: feeds the NTT RAM of the polynomial unit.
// Takes a valid/ready stream of 12-bit coefficients and reduces each one mod Q.
// Packs four coefficients into each RAM word and writes one frame of 2^ADDWID words.
// Pulses done together with the write of the last word of the frame.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; coef_ready low, no RAM activity
//   LOAD  | accepting coefficients, packing lanes, writing full words
//   LAST  | final word is being written this cycle; done pulses here
//
// All outputs are registered.
// coef_ready is updated together with state, so it always equals (state == LOAD).
// It has no combinational path from coef_valid.
// RDWID must equal 4*WID: each RAM word is four lane registers side by side.
module poly_loader #(
  parameter int WID    = 12,
  parameter int RDWID  = 48,
  parameter int ADDWID = 5,
  parameter int Q      = 3329
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WID-1:0]    coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [RDWID-1:0]  ram_wdata,
  output logic [ADDWID-1:0] ram_waddr,
  output logic              ram_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam logic [WID-1:0]    QW       = WID'(Q);
  localparam logic [ADDWID-1:0] WORD_MAX = '1;

  state_t            state;
  logic [1:0]        lane;
  logic [ADDWID-1:0] word_cnt;
  logic [WID-1:0]    lane0_q;
  logic [WID-1:0]    lane1_q;
  logic [WID-1:0]    lane2_q;

  logic              xfer;
  logic              lane_full;
  logic              frame_end;
  logic [WID-1:0]    reduced;

  // Input values are below 2*Q, so one conditional subtraction reduces them fully.
  always_comb begin
    reduced = coef_in;
    if (coef_in >= QW) begin
      reduced = coef_in - QW;
    end
  end

  assign xfer      = coef_valid & coef_ready;
  assign lane_full = (lane == 2'd3);
  assign frame_end = lane_full && (word_cnt == WORD_MAX);

  // Handshake FSM: controls lane packing, RAM word writes and frame status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= 2'd0;
      word_cnt   <= '0;
      lane0_q    <= '0;
      lane1_q    <= '0;
      lane2_q    <= '0;
      coef_ready <= 1'b0;
      ram_wdata  <= '0;
      ram_waddr  <= '0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            coef_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            case (lane)
              2'd0: lane0_q <= reduced;
              2'd1: lane1_q <= reduced;
              2'd2: lane2_q <= reduced;
              default: begin
                // The fourth lane goes straight into the word.
                // The lane registers are not updated for it.
                ram_wdata <= {reduced, lane2_q, lane1_q, lane0_q};
                ram_waddr <= word_cnt;
                ram_we    <= 1'b1;
                word_cnt  <= word_cnt + 1'b1;
              end
            endcase
            lane <= lane + 2'd1;
            if (frame_end) begin
              state      <= LAST;
              coef_ready <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        LAST: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          coef_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_loader.sv
// Scoreboard bench for poly_loader.
// The stimulus side models the packing and reduction, then queues the expected RAM writes.
// The monitor pops and compares one queued entry on every ram_we.
module tb_poly_loader;

  localparam int WID    = 12;
  localparam int RDWID  = 48;
  localparam int ADDWID = 5;
  localparam int Q      = 3329;

  typedef struct {
    logic [ADDWID-1:0] addr;
    logic [RDWID-1:0]  data;
    logic              last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [WID-1:0]    coef_in;
  logic              coef_valid;
  logic              coef_ready;
  logic [RDWID-1:0]  ram_wdata;
  logic [ADDWID-1:0] ram_waddr;
  logic              ram_we;
  logic              busy;
  logic              done;

  poly_loader #(.WID(WID), .RDWID(RDWID), .ADDWID(ADDWID), .Q(Q)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .ram_wdata  (ram_wdata),
    .ram_waddr  (ram_waddr),
    .ram_we     (ram_we),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  exp_t           sb[$];
  int             wr_cyc[$];
  int             cyc = 0;
  int             done_cnt = 0;
  logic [RDWID-1:0] word0_seen = '0;

  int             mk = 0;
  int             mword = 0;
  logic [WID-1:0] mlane [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every RAM write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ram_we) begin
      wr_cyc.push_back(cyc);
      if (ram_waddr == '0) word0_seen = ram_wdata;
      if (done) done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_we", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("waddr", ram_waddr, e.addr);
        chk("wdata", ram_wdata, e.data);
        chk("done_on_we", done, e.last);
      end
    end else if (done) begin
      chk("done_without_we", done, 0);
    end
  end

  function automatic logic [WID-1:0] ref_reduce(input logic [WID-1:0] v);
    return (v >= WID'(Q)) ? v - WID'(Q) : v;
  endfunction

  // Reference model of one accepted coefficient.
  task automatic model_accept(input logic [WID-1:0] v);
    exp_t e;
    mlane[mk] = ref_reduce(v);
    mk++;
    if (mk == 4) begin
      e.addr = ADDWID'(mword);
      e.data = {mlane[3], mlane[2], mlane[1], mlane[0]};
      e.last = (mword == 31);
      sb.push_back(e);
      mword = (mword + 1) % 32;
      mk = 0;
    end
  endtask

  task automatic do_start(input bit with_valid);
    start = 1'b1;
    coef_valid = with_valid;
    coef_in = 12'd999;
    chk("ready_in_start_cycle", coef_ready, 0);
    @(negedge clk);
    start = 1'b0;
    coef_valid = 1'b0;
  endtask

  task automatic send(input logic [WID-1:0] v, input bit gap, input bit strt);
    coef_in = v;
    coef_valid = 1'b1;
    start = strt;
    chk("ready_in_load", coef_ready, 1);
    model_accept(v);
    @(negedge clk);
    start = 1'b0;
    if (gap) begin
      coef_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic logic [WID-1:0] val_of(input int mode, input int k);
    case (mode)
      1: begin
        case (k)
          0: return 12'd3328;
          1: return 12'd3329;
          2: return 12'd4095;
          3: return 12'd0;
          default: return WID'($urandom_range(0, 4095));
        endcase
      end
      2: return WID'((k * 31) % 4096);
      default: return WID'(k);
    endcase
  endfunction

  // One complete frame.
  // mode selects the data; gap inserts an idle cycle after each coefficient.
  // start_at_done pulses start in the LAST cycle, where the loader must ignore it.
  task automatic run_frame(input int mode, input bit gap, input bit start_at_done);
    do_start(mode == 1);
    for (int k = 0; k < 128; k++) begin
      send(val_of(mode, k), gap && (k != 127), (mode == 1) && (k == 10));
    end
    coef_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 1);
    chk("ready_at_done", coef_ready, 0);
    start = start_at_done;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", coef_ready, 0);
    @(negedge clk);
    chk("ready_idle_after_frame", coef_ready, 0);
    chk("busy_idle_after_frame", busy, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    start = 1'b0;
    coef_in = '0;
    coef_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", coef_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Idle stability: valid held high without start.
    coef_valid = 1'b1;
    coef_in = 12'd77;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_ready", coef_ready, 0);
      chk("idle_we", ram_we, 0);
    end
    coef_valid = 1'b0;
    @(negedge clk);

    // Basic frame with coefficient k = k.
    run_frame(0, 1'b0, 1'b0);
    chk("basic_word0", word0_seen, 48'h003002001000);

    // Reduction boundaries: valid is high in the start cycle and a mid-frame start is pulsed.
    // start is also pulsed in the done cycle.
    run_frame(1, 1'b0, 1'b1);
    chk("reduce_word0", word0_seen, {12'd0, 12'd766, 12'd0, 12'd3328});

    // Gapped frame: must restart at address 0, and writes land 8 cycles apart.
    base = wr_cyc.size();
    run_frame(0, 1'b1, 1'b0);
    chk("gap_word0", word0_seen, 48'h003002001000);
    chk("gap_write_count", wr_cyc.size() - base, 32);
    for (int i = base + 1; i < wr_cyc.size(); i++) begin
      chk("gap_spacing", wr_cyc[i] - wr_cyc[i-1], 8);
    end

    // Reset after 50 coefficients.
    do_start(1'b0);
    for (int k = 0; k < 50; k++) send(WID'(4000 - k), 1'b0, 1'b0);
    rst = 1'b1;
    coef_valid = 1'b1;
    coef_in = 12'd5;
    @(negedge clk);
    chk("abort_we", ram_we, 0);
    chk("abort_ready", coef_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    coef_valid = 1'b0;
    mk = 0;
    mword = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_we", ram_we, 0);
    end
    chk("post_abort_queue", sb.size(), 0);
    chk("post_abort_done_count", done_cnt, 3);

    // A fresh frame must leave no stale lane data in any word.
    run_frame(2, 1'b0, 1'b0);
    chk("fresh_word0", word0_seen, {12'd93, 12'd62, 12'd31, 12'd0});

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("done_count", done_cnt, 4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/poly_loader.md
Name: poly_loader

Overview:
- Upstream feeder for the polynomial unit's NTT RAM.
- Accepts a stream of 12-bit coefficients over a valid/ready handshake and reduces each into [0, Q-1] with one conditional subtraction.
- Packs four reduced coefficients per 48-bit RAM word and writes one 32-word frame (128 coefficients) to addresses 0..31.
- Pulses done when the frame is complete, so the controller can then run the polynomial unit in NTT/INTT/bypass mode.

Parameters:
- WID, 12, coefficient width.
- RDWID, 48, RAM word width; must equal 4*WID.
- ADDWID, 5, RAM address width; frame length is 2^ADDWID words.
- Q, 3329, modulus used for reduction.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms loading of a new frame.
- coef_in  in  WID  input coefficient, unsigned 0..4095.
- coef_valid  in  1  coef_in is valid this cycle.
- coef_ready  out  1  loader accepts coef_in this cycle.
- ram_wdata  out  RDWID  packed word to NTT RAM write port.
- ram_waddr  out  ADDWID  RAM write address.
- ram_we  out  1  RAM write enable, one cycle per word.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse on the final word write.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: coef_ready=0, ram_we=0, ram_wdata=0, ram_waddr=0, busy=0, done=0. Lane, lane counter and word counter all clear to 0.
- States are IDLE, LOAD and LAST.
  - IDLE -> LOAD on start. coef_ready rises the cycle after start; a coef_valid in the start cycle is not accepted.
  - LOAD -> LAST on acceptance of coefficient 127.
  - LAST -> IDLE unconditionally after one cycle.
- start is ignored in LOAD and LAST.
- coef_ready = (state==LOAD). It is a pure state decode, with no combinational path from coef_valid.
- Transfer occurs when coef_valid & coef_ready. With coef_valid low, nothing advances; gaps of any length are legal.
- Reduction: r = (coef_in >= Q) ? coef_in - Q : coef_in. Only values 3329..4095 are subtracted; 3328 passes unchanged.
- Packing: the k-th accepted coefficient (k = 0..127) is written to word k>>2, bits [WID*(k%4)+WID-1 : WID*(k%4)]. Lane 0 is the LSBs.
- The lane counter wraps 3->0. On the transfer that fills lane 3:
  - next cycle ram_we=1;
  - ram_wdata = the four reduced lanes;
  - ram_waddr = word counter;
  - word counter then increments.
- Latency: the 4th-lane accept in cycle t produces the write in cycle t+1. Lanes 0..2 are held in registers; no RAM write for partial words.
- ram_wdata and ram_waddr hold their last values while ram_we=0.
- The final word (address 31) is written in the LAST cycle. done=1 in the same cycle as that ram_we.
- Word counter wraps 31->0, so it is 0 again for the next frame.
- busy = (state != IDLE), and drops the cycle after done.
- Back-to-back frames: start in the cycle done is high is ignored (state is LAST). Next start is accepted from IDLE.
- rst mid-frame: abort and return to reset values next cycle. No further RAM writes; partial lanes are discarded; done is not pulsed.
- No backpressure from the RAM: the write port accepts every cycle.

Test Plan:
- Basic frame: start, then 128 back-to-back coefficients k=0..127 with value k. Expect:
  - 32 writes;
  - word 0 = {12'd3,12'd2,12'd1,12'd0} = 48'h003002001000;
  - done with waddr=31;
  - busy low the following cycle.
- Reduction boundaries: lanes 3328, 3329, 4095, 0. Expect the word to contain 3328, 0, 766, 0 in lanes 0..3.
- Gapped valid: coef_valid toggles 1/0 every cycle. Expect the identical RAM contents as the basic frame, with writes spaced 8 cycles apart.
- Start protocol:
  - coef_valid high in the start cycle: that coefficient is not consumed;
  - start pulsed mid-frame: no effect on counters;
  - second frame after done: writes restart at address 0.
- Reset mid-frame: rst after 50 coefficients. Expect:
  - ram_we, coef_ready and busy low the next cycle;
  - no done;
  - a fresh start and frame write addresses 0..31 correctly, with no leftover lane data.
- Idle stability: no start, coef_valid held high for 100 cycles. Expect coef_ready=0 and ram_we=0 throughout.
